// File: rtl/upsample.sv
// 28x28 -> 112x112 binary pixel expander: ping-pong line buffers on the input,
// a two-state read FSM that replicates each buffered row SCALE x SCALE.
module upsample #(
    parameter int SRC_W = 28,
    parameter int SRC_H = 28,
    parameter int SCALE = 4
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic bin_data,
    input  logic bin_data_vld,
    output logic up_rdy,
    output logic up_data,
    output logic up_data_vld,
    output logic up_eof
);
    localparam int OUT_W = SRC_W * SCALE;
    localparam int OUT_H = SRC_H * SCALE;
    localparam int CW    = $clog2(SRC_W);
    localparam int OCW   = $clog2(OUT_W);
    localparam int RW    = $clog2(OUT_H);
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t                 state, state_nxt;
    logic [1:0][SRC_W-1:0]  line_buf;
    logic [1:0]             full;
    logic                   wr_sel, rd_sel;
    logic [CW-1:0]          wr_col;
    logic [OCW-1:0]         out_col;
    logic [OCW-1:0]         src_idx;
    logic [SW-1:0]          rep_cnt;
    logic [RW-1:0]          out_row;
    logic                   accept, wr_last, col_last, grp_last;

    assign up_rdy   = !full[wr_sel];
    assign accept   = bin_data_vld && up_rdy;
    assign wr_last  = accept && (wr_col == CW'(SRC_W - 1));
    assign col_last = (out_col == OCW'(OUT_W - 1));
    assign grp_last = (state == EXPAND) && col_last && (rep_cnt == SW'(SCALE - 1));
    assign src_idx  = out_col / OCW'(SCALE);

    // Stay in EXPAND across a row-group boundary when the other buffer is
    // already waiting, so back-to-back rows come out without a bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rd_sel]) state_nxt = EXPAND;
            EXPAND:  if (grp_last && !full[~rd_sel]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= IDLE;
            line_buf    <= '0;
            full        <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_col      <= '0;
            out_col     <= '0;
            rep_cnt     <= '0;
            out_row     <= '0;
            up_data     <= 1'b0;
            up_data_vld <= 1'b0;
            up_eof      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                line_buf[wr_sel][wr_col] <= bin_data;
                if (wr_last) begin
                    wr_col <= '0;
                    wr_sel <= ~wr_sel;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end

            // Writer only sets a non-full buffer, reader only clears a full one.
            for (int i = 0; i < 2; i++) begin
                if (wr_last && wr_sel == 1'(i))
                    full[i] <= 1'b1;
                else if (grp_last && rd_sel == 1'(i))
                    full[i] <= 1'b0;
            end

            if (state == IDLE) begin
                up_data     <= 1'b0;
                up_data_vld <= 1'b0;
                up_eof      <= 1'b0;
                out_col     <= '0;
                rep_cnt     <= '0;
            end else begin
                up_data     <= line_buf[rd_sel][src_idx[CW-1:0]];
                up_data_vld <= 1'b1;
                up_eof      <= col_last && (out_row == RW'(OUT_H - 1));
                if (col_last) begin
                    out_col <= '0;
                    rep_cnt <= (rep_cnt == SW'(SCALE - 1)) ? '0 : rep_cnt + 1'b1;
                    out_row <= (out_row == RW'(OUT_H - 1)) ? '0 : out_row + 1'b1;
                    if (grp_last) rd_sel <= ~rd_sel;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_upsample.sv
// Scoreboard bench for upsample: random source frames, expected 112x112 stream
// built from whole accepted rows, checked by an independent output monitor.
module tb_upsample;
    localparam int SRC_W = 28;
    localparam int SRC_H = 28;
    localparam int SCALE = 4;
    localparam int OUT_W = SRC_W * SCALE;
    localparam int OUT_H = SRC_H * SCALE;
    localparam int FRAME_OUT = OUT_W * OUT_H;

    logic sclk = 1'b0, s_rst_n = 1'b0, bin_data = 1'b0, bin_data_vld = 1'b0;
    logic up_rdy, up_data, up_data_vld, up_eof;

    upsample #(.SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .bin_data(bin_data), .bin_data_vld(bin_data_vld),
        .up_rdy(up_rdy), .up_data(up_data), .up_data_vld(up_data_vld), .up_eof(up_eof)
    );

    always #5 sclk = ~sclk;

    typedef struct packed { logic d; logic eof; } exp_t;
    exp_t exp_q[$];
    bit   row_buf[$];
    int   exp_pix_cnt;
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, acc_cnt, acc_cyc, first_vld_cyc, vld_cnt, rise_cnt, eof_cnt, stall_at;
    bit   prev_vld, bp_chk;

    always @(posedge sclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each completed source row becomes SCALE identical lines,
    // each source pixel repeated SCALE times; eof on every FRAME_OUT-th pixel.
    task automatic model_accept(input bit d);
        exp_t e;
        row_buf.push_back(d);
        if (row_buf.size() == SRC_W) begin
            for (int r = 0; r < SCALE; r++)
                for (int c = 0; c < OUT_W; c++) begin
                    exp_pix_cnt++;
                    e.d   = row_buf[c / SCALE];
                    e.eof = (exp_pix_cnt % FRAME_OUT) == 0;
                    exp_q.push_back(e);
                end
            row_buf.delete();
        end
    endtask

    always @(negedge sclk) begin
        exp_t e;
        if (s_rst_n) begin
            if (up_data_vld) begin
                vld_cnt++;
                if (!prev_vld) rise_cnt++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (up_eof) eof_cnt++;
                if (exp_q.size() == 0) check("unexpected_vld", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("up_data", up_data, e.d);
                    check("up_eof", up_eof, e.eof);
                end
                if (bp_chk && vld_cnt == SCALE * OUT_W - 1) check("rdy_before_free", up_rdy, 0);
                if (bp_chk && vld_cnt == SCALE * OUT_W)     check("rdy_after_free", up_rdy, 1);
            end else if (up_eof) begin
                check("eof_without_vld", 1, 0);
            end
            prev_vld = up_data_vld;
        end
    end

    task automatic do_reset();
        @(posedge sclk); #1;
        s_rst_n = 1'b0; bin_data_vld = 1'b0; bin_data = 1'b0;
        exp_q.delete(); row_buf.delete(); exp_pix_cnt = 0;
        @(negedge sclk);
        check("rst_up_data", up_data, 0);
        check("rst_up_vld", up_data_vld, 0);
        check("rst_up_eof", up_eof, 0);
        repeat (2) @(posedge sclk);
        #1 s_rst_n = 1'b1;
        prev_vld = 0; vld_cnt = 0; rise_cnt = 0; eof_cnt = 0;
        first_vld_cyc = -1; acc_cnt = 0; stall_at = -1;
        @(negedge sclk);
        check("rdy_after_rst", up_rdy, 1);
        @(posedge sclk); #1;
    endtask

    task automatic send_px(input logic d);
        int t = 0;
        bin_data = d; bin_data_vld = 1'b1;
        @(negedge sclk);
        while (!up_rdy) begin
            if (stall_at < 0) stall_at = acc_cnt;
            t++;
            if (t > 3000) begin check("rdy_timeout", 0, 1); return; end
            @(negedge sclk);
        end
        acc_cnt++; acc_cyc = cyc;
        model_accept(d);
        @(posedge sclk); #1;
    endtask

    // mode 0 random, 1 all zeros, 2 all ones; gaps inserts random idle cycles
    task automatic send_frame(input int mode, input bit gaps);
        for (int i = 0; i < SRC_W * SRC_H; i++) begin
            send_px(mode == 0 ? 1'($urandom_range(1)) : (mode == 2));
            if (gaps && $urandom_range(3) == 0) begin
                bin_data_vld = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge sclk);
                #1;
            end
        end
    endtask

    task automatic drain();
        bin_data_vld = 1'b0;
        for (int t = 0; t < 20000 && exp_q.size() != 0; t++) @(negedge sclk);
        check("drain_left", exp_q.size(), 0);
        repeat (4) @(negedge sclk);
        check("vld_idle", up_data_vld, 0);
        @(posedge sclk); #1;
    endtask

    initial begin
        do_reset();

        // single row 1010..., idle afterwards
        for (int c = 0; c < SRC_W; c++) send_px(c % 2 == 0);
        drain();
        check("row_valids", vld_cnt, SCALE * OUT_W);
        check("row_latency", first_vld_cyc - acc_cyc, 3);
        check("row_bursts", rise_cnt, 1);
        check("row_eofs", eof_cnt, 0);

        // full random frame, vld held high from reset: backpressure + gapless handoff
        do_reset();
        bp_chk = 1;
        send_frame(0, 0);
        drain();
        bp_chk = 0;
        check("frame_valids", vld_cnt, FRAME_OUT);
        check("frame_bursts", rise_cnt, 1);
        check("frame_eofs", eof_cnt, 1);
        check("stall_at", stall_at, 2 * SRC_W);

        // reset after 15 pixels of row 3, then a fresh frame with input gaps
        do_reset();
        for (int i = 0; i < 3 * SRC_W + 15; i++) send_px(1'($urandom_range(1)));
        do_reset();
        send_frame(0, 1);
        drain();
        check("rst_frame_valids", vld_cnt, FRAME_OUT);
        check("rst_frame_eofs", eof_cnt, 1);

        // extremes
        do_reset();
        send_frame(1, 0);
        drain();
        check("zero_frame_valids", vld_cnt, FRAME_OUT);
        check("zero_frame_eofs", eof_cnt, 1);
        do_reset();
        send_frame(2, 0);
        drain();
        check("one_frame_valids", vld_cnt, FRAME_OUT);
        check("one_frame_eofs", eof_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
